wb_queue: RTL and testbench

//  Writeback buffer directly upstream of the 8x16 register file write port.
//  - Accepts results from two producers: the single-cycle ALU and the load unit (MEM).
//  - Queues them in order in a small FIFO.
//  - Drains one entry per cycle onto the regfile wr_en/wr_addr/wr_data port.
//  - Decouples producer bursts from the regfile's single write port.

---
 rtl/wb_queue.sv | 108 ++++++++++
 tb/tb_wb_queue.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// Writeback queue between the ALU/load producers and the single regfile write port.
// Optional WBQ_FWD_EN adds a combinational bypass search over pending writes.
module wb_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [AW-1:0]            alu_addr,
    input  logic [DW-1:0]            alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [AW-1:0]            mem_addr,
    input  logic [DW-1:0]            mem_data,
    input  logic                     wb_hold,
    output logic                     wr_en,
    output logic [AW-1:0]            wr_addr,
    output logic [DW-1:0]            wr_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
`ifdef WBQ_FWD_EN
    ,
    input  logic [AW-1:0]            fwd_addr,
    output logic                     fwd_hit,
    output logic [DW-1:0]            fwd_data
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] q_addr [DEPTH];
    logic [DW-1:0] q_data [DEPTH];
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [PW-1:0] mem_slot;
    logic          alu_push;
    logic          mem_push;
    logic          pop;

    // Ready looks only at the registered count; a same-cycle pop earns no credit.
    assign alu_ready = count < CW'(DEPTH);
    assign mem_ready = (count + CW'(alu_valid)) < CW'(DEPTH);
    assign alu_push  = alu_valid & alu_ready;
    assign mem_push  = mem_valid & mem_ready;
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign pop       = ~empty & ~wb_hold;
    assign mem_slot  = alu_push ? wptr + PW'(1) : wptr;

    always_ff @(posedge clk) begin
        if (alu_push) begin
            q_addr[wptr] <= alu_addr;
            q_data[wptr] <= alu_data;
        end
        if (mem_push) begin
            q_addr[mem_slot] <= mem_addr;
            q_data[mem_slot] <= mem_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr    <= '0;
            wptr    <= '0;
            count   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wptr  <= wptr + PW'(alu_push) + PW'(mem_push);
            rptr  <= rptr + PW'(pop);
            count <= count + CW'(alu_push) + CW'(mem_push) - CW'(pop);
            wr_en <= pop;
            if (pop) begin
                wr_addr <= q_addr[rptr];
                wr_data <= q_data[rptr];
            end
        end
    end

`ifdef WBQ_FWD_EN
    logic [PW-1:0] fwd_idx;

    // Scan oldest to youngest so the last match found is the youngest pending write.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        if (wr_en && (wr_addr == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = wr_data;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = rptr + PW'(i);
            if ((CW'(i) < count) && (q_addr[fwd_idx] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = q_data[fwd_idx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Randomized bench for wb_queue against a queue-based reference model plus directed literal checks.
module tb_wb_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 3;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          wb_hold;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
`ifdef WBQ_FWD_EN
    logic [AW-1:0] fwd_addr;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
`endif

    wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .wb_hold(wb_hold), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .count(count), .full(full), .empty(empty)
`ifdef WBQ_FWD_EN
        , .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending writes as a plain queue of {addr,data}, plus the write stage.
    logic [AW+DW-1:0] mq[$];
    logic             exp_wr_en;
    logic [AW-1:0]    exp_wr_addr;
    logic [DW-1:0]    exp_wr_data;

    int nvec = 0;
    int ncmp = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_wr_en   = 1'b0;
        exp_wr_addr = '0;
        exp_wr_data = '0;
    endtask

    // Called at a falling edge: drive, compare, take the rising edge, advance model, return at next falling edge.
    task automatic step(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                        input logic h, output logic acc_a, output logic acc_m);
        int sz;
        logic [AW+DW-1:0] head;
        logic e_ar, e_mr;
`ifdef WBQ_FWD_EN
        logic e_hit;
        logic [DW-1:0] e_fd;
`endif
        alu_valid = av; alu_addr = aa; alu_data = ad;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        wb_hold = h;
`ifdef WBQ_FWD_EN
        fwd_addr = AW'($urandom);
`endif
        #1;
        nvec++;
        sz   = mq.size();
        e_ar = (sz < DEPTH);
        e_mr = (sz + int'(av) < DEPTH);
        chk("alu_ready", 32'(alu_ready), 32'(e_ar));
        chk("mem_ready", 32'(mem_ready), 32'(e_mr));
        chk("count", 32'(count), 32'(sz));
        chk("full", 32'(full), 32'(sz == DEPTH));
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("wr_en", 32'(wr_en), 32'(exp_wr_en));
        chk("wr_addr", 32'(wr_addr), 32'(exp_wr_addr));
        chk("wr_data", 32'(wr_data), 32'(exp_wr_data));
`ifdef WBQ_FWD_EN
        e_hit = exp_wr_en && (exp_wr_addr == fwd_addr);
        e_fd  = exp_wr_data;
        foreach (mq[i]) begin
            if (mq[i][AW+DW-1:DW] == fwd_addr) begin
                e_hit = 1'b1;
                e_fd  = mq[i][DW-1:0];
            end
        end
        chk("fwd_hit", 32'(fwd_hit), 32'(e_hit));
        if (e_hit) chk("fwd_data", 32'(fwd_data), 32'(e_fd));
`endif
        acc_a = av && e_ar;
        acc_m = mv && e_mr;
        @(posedge clk);
        if (sz > 0 && !h) begin
            head        = mq.pop_front();
            exp_wr_en   = 1'b1;
            exp_wr_addr = head[AW+DW-1:DW];
            exp_wr_data = head[DW-1:0];
        end else begin
            exp_wr_en = 1'b0;
        end
        if (acc_a) mq.push_back({aa, ad});
        if (acc_m) mq.push_back({ma, md});
        @(negedge clk);
    endtask

    task automatic idle(input logic h);
        logic a, m;
        step(1'b0, '0, '0, 1'b0, '0, '0, h, a, m);
    endtask

    task automatic push_alu(input logic [AW-1:0] aa, input logic [DW-1:0] ad, input logic h);
        logic a, m;
        step(1'b1, aa, ad, 1'b0, '0, '0, h, a, m);
    endtask

    initial begin
        logic a, m;
        logic av, mv, h, acc_a, acc_m;
        logic [AW-1:0] aa, ma;
        logic [DW-1:0] ad, md;

        rst = 1'b1;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        wb_hold = 1'b0;
`ifdef WBQ_FWD_EN
        fwd_addr = '0;
`endif
        model_reset();
        #1;
        chk("rst count", 32'(count), 32'd0);
        chk("rst empty", 32'(empty), 32'd1);
        chk("rst full", 32'(full), 32'd0);
        chk("rst wr_en", 32'(wr_en), 32'd0);
        chk("rst wr_addr", 32'(wr_addr), 32'd0);
        chk("rst wr_data", 32'(wr_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single ALU push reaches the write port after the following edge.
        push_alu(3'd3, 16'h1234, 1'b0);
        chk("t2 count", 32'(count), 32'd1);
        idle(1'b0);
        chk("t2 wr_en", 32'(wr_en), 32'd1);
        chk("t2 wr_addr", 32'(wr_addr), 32'd3);
        chk("t2 wr_data", 32'(wr_data), 32'h1234);
        chk("t2 empty", 32'(empty), 32'd1);

        // ALU and MEM on the same edge: ALU drains first.
        step(1'b1, 3'd1, 16'h00AA, 1'b1, 3'd2, 16'h00BB, 1'b0, a, m);
        chk("t3 count", 32'(count), 32'd2);
        idle(1'b0);
        chk("t3 first addr", 32'(wr_addr), 32'd1);
        chk("t3 first data", 32'(wr_data), 32'h00AA);
        idle(1'b0);
        chk("t3 second en", 32'(wr_en), 32'd1);
        chk("t3 second addr", 32'(wr_addr), 32'd2);
        chk("t3 second data", 32'(wr_data), 32'h00BB);
        idle(1'b0);
        chk("t3 idle en", 32'(wr_en), 32'd0);

        // Fill under hold, then release for four back-to-back writes.
        for (int i = 0; i < 4; i++) push_alu(AW'(i), DW'(16'h0100 + i), 1'b1);
        alu_valid = 1'b1; mem_valid = 1'b1; wb_hold = 1'b1;
        #1;
        chk("t4 full", 32'(full), 32'd1);
        chk("t4 alu_ready", 32'(alu_ready), 32'd0);
        chk("t4 mem_ready", 32'(mem_ready), 32'd0);
        chk("t4 wr_en", 32'(wr_en), 32'd0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            chk("t4 drain en", 32'(wr_en), 32'd1);
            chk("t4 drain addr", 32'(wr_addr), 32'(i));
            chk("t4 drain data", 32'(wr_data), 32'(16'h0100 + i));
        end
        idle(1'b0);
        chk("t4 done en", 32'(wr_en), 32'd0);

        // Three queued: ALU accepted, MEM refused.
        for (int i = 0; i < 3; i++) push_alu(AW'(4 + i), DW'(16'h0200 + i), 1'b1);
        alu_valid = 1'b1; alu_addr = 3'd7; alu_data = 16'h02AA;
        mem_valid = 1'b1; mem_addr = 3'd6; mem_data = 16'h02BB;
        wb_hold = 1'b1;
        #1;
        chk("t5 alu_ready", 32'(alu_ready), 32'd1);
        chk("t5 mem_ready", 32'(mem_ready), 32'd0);
        step(1'b1, 3'd7, 16'h02AA, 1'b1, 3'd6, 16'h02BB, 1'b1, a, m);
        chk("t5 count", 32'(count), 32'd4);
        for (int i = 0; i < 5; i++) idle(1'b0);

        // Random traffic; a refused producer holds its transaction.
        av = 1'b0; mv = 1'b0; acc_a = 1'b1; acc_m = 1'b1;
        aa = '0; ad = '0; ma = '0; md = '0;
        for (int n = 0; n < 400; n++) begin
            if (!av || acc_a) begin
                av = ($urandom_range(0, 9) < 6);
                aa = AW'($urandom);
                ad = DW'($urandom);
            end
            if (!mv || acc_m) begin
                mv = ($urandom_range(0, 9) < 6);
                ma = AW'($urandom);
                md = DW'($urandom);
            end
            h = ($urandom_range(0, 3) == 0);
            step(av, aa, ad, mv, ma, md, h, acc_a, acc_m);
        end
        for (int i = 0; i < 6; i++) idle(1'b0);

        // Asynchronous reset between edges with three entries pending and a write in flight.
        for (int i = 0; i < 4; i++) push_alu(AW'(i), DW'(16'h0300 + i), 1'b1);
        idle(1'b0);
        chk("t1 pre count", 32'(count), 32'd3);
        chk("t1 pre wr_en", 32'(wr_en), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("t1 count", 32'(count), 32'd0);
        chk("t1 wr_en", 32'(wr_en), 32'd0);
        chk("t1 empty", 32'(empty), 32'd1);
        chk("t1 full", 32'(full), 32'd0);
        chk("t1 wr_addr", 32'(wr_addr), 32'd0);
        chk("t1 wr_data", 32'(wr_data), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            chk("t1 post wr_en", 32'(wr_en), 32'd0);
        end

`ifdef WBQ_FWD_EN
        step(1'b1, 3'd5, 16'h0001, 1'b1, 3'd5, 16'h0002, 1'b1, a, m);
        fwd_addr = 3'd5;
        #1;
        chk("t6 hit5", 32'(fwd_hit), 32'd1);
        chk("t6 data5", 32'(fwd_data), 32'h0002);
        fwd_addr = 3'd6;
        #1;
        chk("t6 hit6", 32'(fwd_hit), 32'd0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) idle(1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
